alu32_pipe: RTL



---
 rtl/alu32_pkg.sv | 32 +++
 rtl/alu32_pipe_if.sv | 28 ++
 rtl/alu32_shift_unit.sv | 25 ++
 rtl/alu32_pipe.sv | 119 +++++++++++
 4 files changed

// File: rtl/alu32_pkg.sv
// Shared definitions for the two-stage ALU execution stage: opcodes, widths,
// shift modes and the flag bundle carried alongside the result.
package alu32_pkg;

  localparam int WIDTH   = 32;
  localparam int OPW     = 4;
  localparam int SHAMT_W = 5;

  localparam logic [OPW-1:0] OP_AND  = 4'd0;
  localparam logic [OPW-1:0] OP_OR   = 4'd1;
  localparam logic [OPW-1:0] OP_XOR  = 4'd2;
  localparam logic [OPW-1:0] OP_NOR  = 4'd3;
  localparam logic [OPW-1:0] OP_ADD  = 4'd4;
  localparam logic [OPW-1:0] OP_SUB  = 4'd5;
  localparam logic [OPW-1:0] OP_SLT  = 4'd6;
  localparam logic [OPW-1:0] OP_SLTU = 4'd7;
  localparam logic [OPW-1:0] OP_SLL  = 4'd8;
  localparam logic [OPW-1:0] OP_SRL  = 4'd9;
  localparam logic [OPW-1:0] OP_SRA  = 4'd10;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu32_pipe_if.sv
// Issue-side and writeback-side handshake bundle of the ALU execution stage.
interface alu32_pipe_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [OPW-1:0]   Op;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Out;
  logic             Zero;
  logic             Carry;
  logic             Overflow;
  logic             IllegalOp;

  modport master (
    output InValid, In1, In2, Op, OutReady,
    input  InReady, OutValid, Out, Zero, Carry, Overflow, IllegalOp
  );

  modport slave (
    input  InValid, In1, In2, Op, OutReady,
    output InReady, OutValid, Out, Zero, Carry, Overflow, IllegalOp
  );
endinterface

// File: rtl/alu32_shift_unit.sv
// Combinational barrel shifter: logical left, logical right, arithmetic right.
module alu32_shift_unit
  import alu32_pkg::*;
(
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   result
);

  logic signed [WIDTH-1:0] data_s;

  assign data_s = data;

  always_comb begin
    result = data;
    case (mode)
      SH_SLL:  result = data << shamt;
      SH_SRL:  result = data >> shamt;
      SH_SRA:  result = data_s >>> shamt;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/alu32_pipe.sv
// Two-stage pipelined 32-bit ALU: stage 1 registers operands, stage 2 registers
// the computed result and flags; valid/ready on both sides with full throughput.
module alu32_pipe #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  alu32_pipe_if.slave  bus
);
  import alu32_pkg::*;

  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv, in_xfer, out_xfer;
  logic [WIDTH-1:0] a_p1, b_p1;
  logic [OPW-1:0]   op_p1;
  logic [WIDTH-1:0] out_p2;
  alu_flags_t       flags_p2;

  logic [WIDTH-1:0]        res_c, shift_c;
  alu_flags_t              flags_c;
  logic [WIDTH:0]          sum_w, diff_w;
  logic signed [WIDTH-1:0] a_s, b_s;

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign s2_adv      = !s2_valid || bus.OutReady;
  assign s1_adv      = s1_valid && s2_adv;
  assign bus.InReady = !s1_valid || s2_adv;
  assign in_xfer     = bus.InValid && bus.InReady;
  assign out_xfer    = s2_valid && bus.OutReady;

  // ---- stage 1: operand capture ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)          s1_valid <= 1'b0;
    else if (in_xfer) s1_valid <= 1'b1;
    else if (s1_adv)  s1_valid <= 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (in_xfer) begin
      a_p1  <= bus.In1;
      b_p1  <= bus.In2;
      op_p1 <= bus.Op;
    end
  end

  // ---- stage 1 -> 2: execute ----
  // SLL/SRL/SRA opcodes 8/9/10 map directly onto shift modes 0/1/2 via the low bits.
  alu32_shift_unit u_shift (
    .data   (a_p1),
    .shamt  (b_p1[SHAMT_W-1:0]),
    .mode   (op_p1[1:0]),
    .result (shift_c)
  );

  assign a_s    = a_p1;
  assign b_s    = b_p1;
  assign sum_w  = {1'b0, a_p1} + {1'b0, b_p1};
  assign diff_w = {1'b0, a_p1} + {1'b0, ~b_p1} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_c   = '0;
    flags_c = '0;
    case (op_p1)
      OP_AND:  res_c = a_p1 & b_p1;
      OP_OR:   res_c = a_p1 | b_p1;
      OP_XOR:  res_c = a_p1 ^ b_p1;
      OP_NOR:  res_c = ~(a_p1 | b_p1);
      OP_ADD: begin
        res_c            = sum_w[WIDTH-1:0];
        flags_c.carry    = sum_w[WIDTH];
        flags_c.overflow = add_ovf(a_p1, b_p1, sum_w[WIDTH-1:0]);
      end
      OP_SUB: begin
        res_c            = diff_w[WIDTH-1:0];
        flags_c.carry    = diff_w[WIDTH];
        flags_c.overflow = sub_ovf(a_p1, b_p1, diff_w[WIDTH-1:0]);
      end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (a_p1 < b_p1)};
      OP_SLL, OP_SRL, OP_SRA: res_c = shift_c;
      default: flags_c.illegal = 1'b1;
    endcase
    // Undefined opcodes report only IllegalOp, even though their result is 0.
    flags_c.zero = !flags_c.illegal && (res_c == '0);
  end

  // ---- stage 2: result registers ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s2_valid <= 1'b0;
      out_p2   <= '0;
      flags_p2 <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        out_p2   <= res_c;
        flags_p2 <= flags_c;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.OutValid  = s2_valid;
  assign bus.Out       = out_p2;
  assign bus.Zero      = flags_p2.zero;
  assign bus.Carry     = flags_p2.carry;
  assign bus.Overflow  = flags_p2.overflow;
  assign bus.IllegalOp = flags_p2.illegal;

endmodule
